// File: rtl/pipeline_skid_buffer.sv
// rtl/pipeline_skid_buffer.sv - registered valid/ready stage with one-entry skid register
module pipeline_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    // State encoding equals the number of held words, so occupancy is the state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    // All outputs are pure decodes of registered state: no path from out_ready to in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and datapath: main feeds the output, skid catches the word arriving under stall.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State registers with synchronous active-low reset that discards all held words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// tb/tb_pipeline_skid_buffer.sv - self-checking bench for pipeline_skid_buffer
module tb_pipeline_skid_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] occupancy;

    logic       rst1;
    logic       id1;
    logic       iv1;
    logic       ir1;
    logic       od1;
    logic       ov1;
    logic       or1;
    logic [1:0] occ1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference models: an ordered list of held words, at most two deep.
    logic [7:0] q8[$];
    logic       q1[$];

    logic monitor_en = 1'b0;
    logic seen_bad   = 1'b0;

    typedef struct {
        logic       rn;
        logic       iv;
        logic [7:0] id;
        logic       orr;
        logic [1:0] e_occ;
        logic       e_valid;
        logic [7:0] e_data;
        logic       chk_data;
        logic       e_ready;
    } vec_t;

    vec_t vecs[64];
    int   n_vecs = 0;

    pipeline_skid_buffer #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    pipeline_skid_buffer #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .in_data   (id1),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .out_data  (od1),
        .out_valid (ov1),
        .out_ready (or1),
        .occupancy (occ1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check8();
        chk("occ8", int'(occupancy), q8.size());
        chk("valid8", int'(out_valid), int'(q8.size() > 0));
        chk("ready8", int'(in_ready), int'(q8.size() < 2));
        if (q8.size() > 0) chk("data8", int'(out_data), int'(q8[0]));
    endtask

    task automatic check1();
        chk("occ1", int'(occ1), q1.size());
        chk("valid1", int'(ov1), int'(q1.size() > 0));
        chk("ready1", int'(ir1), int'(q1.size() < 2));
        if (q1.size() > 0) chk("data1", int'(od1), int'(q1[0]));
    endtask

    // Advance the 8-bit model across the coming edge using the inputs now being driven.
    task automatic model8_update();
        logic fire_in, fire_out;
        if (!rst) begin
            q8.delete();
        end else begin
            fire_in  = in_valid && (q8.size() < 2);
            fire_out = out_ready && (q8.size() > 0);
            if (fire_out) void'(q8.pop_front());
            if (fire_in) q8.push_back(in_data);
        end
    endtask

    task automatic model1_update();
        logic fire_in, fire_out;
        if (!rst1) begin
            q1.delete();
        end else begin
            fire_in  = iv1 && (q1.size() < 2);
            fire_out = or1 && (q1.size() > 0);
            if (fire_out) void'(q1.pop_front());
            if (fire_in) q1.push_back(id1);
        end
    endtask

    // Called at a falling edge: drive, advance model, cross one rising edge, check.
    task automatic step(input logic rn, input logic iv, input logic [7:0] id, input logic orr);
        rst       = rn;
        in_valid  = iv;
        in_data   = id;
        out_ready = orr;
        if (monitor_en && rn && out_valid && orr && (out_data == 8'h11 || out_data == 8'h22))
            seen_bad = 1'b1;
        model8_update();
        @(posedge clk);
        @(negedge clk);
        check8();
    endtask

    task automatic add(input logic rn, input logic iv, input logic [7:0] id, input logic orr,
                       input logic [1:0] e_occ, input logic e_valid, input logic [7:0] e_data,
                       input logic chk_data, input logic e_ready);
        vecs[n_vecs] = '{rn, iv, id, orr, e_occ, e_valid, e_data, chk_data, e_ready};
        n_vecs++;
    endtask

    logic       pv8, pr8, pv1, pr1, pd1;
    logic [7:0] pd8;

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        rst1 = 1'b0; iv1 = 1'b0; id1 = 1'b0; or1 = 1'b0;

        // Reset held two cycles with traffic offered, then release.
        add(0, 1, 8'hAA, 0, 0, 0, 8'h00, 1, 1);
        add(0, 1, 8'hAA, 0, 0, 0, 8'h00, 1, 1);
        add(1, 0, 8'hAA, 1, 0, 0, 8'h00, 1, 1);
        // Streaming 0..15 at full rate.
        for (int i = 0; i < 16; i++) add(1, 1, 8'(i), 1, 1, 1, 8'(i), 1, 1);
        add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
        // Stall fill: 01 lands, 02 goes to skid, 03 refused.
        add(1, 1, 8'h01, 0, 1, 1, 8'h01, 1, 1);
        add(1, 1, 8'h02, 0, 2, 1, 8'h01, 1, 0);
        add(1, 1, 8'h03, 0, 2, 1, 8'h01, 1, 0);
        add(1, 1, 8'h03, 0, 2, 1, 8'h01, 1, 0);
        // Drain: 01 leaves, then 02 leaves as 03 enters, then 03 leaves.
        add(1, 1, 8'h03, 1, 1, 1, 8'h02, 1, 1);
        add(1, 1, 8'h03, 1, 1, 1, 8'h03, 1, 1);
        add(1, 0, 8'h03, 1, 0, 0, 8'h00, 0, 1);

        @(negedge clk);
        for (int i = 0; i < n_vecs; i++) begin
            step(vecs[i].rn, vecs[i].iv, vecs[i].id, vecs[i].orr);
            chk($sformatf("vec%0d_occ", i), int'(occupancy), int'(vecs[i].e_occ));
            chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d_ready", i), int'(in_ready), int'(vecs[i].e_ready));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_data", i), int'(out_data), int'(vecs[i].e_data));
        end

        // Reset while FULL: held words must vanish without ever firing.
        step(1, 1, 8'h11, 0);
        step(1, 1, 8'h22, 0);
        chk("full_occ", int'(occupancy), 2);
        step(0, 0, 8'h00, 0);
        chk("rstfull_occ", int'(occupancy), 0);
        chk("rstfull_valid", int'(out_valid), 0);
        chk("rstfull_data", int'(out_data), 0);
        monitor_en = 1'b1;
        step(1, 1, 8'h33, 1);
        chk("after_rst_data", int'(out_data), 8'h33);
        for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 1);
        chk("no_11_22_seen", int'(seen_bad), 0);
        monitor_en = 1'b0;

        // Randomized traffic on both widths against the queue models.
        rst1 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
        model1_update();
        @(posedge clk);
        @(negedge clk);
        pv8 = 1'b0; pr8 = 1'b0; pd8 = 8'h00;
        pv1 = 1'b0; pr1 = 1'b0; pd1 = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            if (pv8 && !pr8) begin
                chk("stall_valid8", int'(out_valid), 1);
                chk("stall_data8", int'(out_data), int'(pd8));
            end
            if (pv1 && !pr1) begin
                chk("stall_valid1", int'(ov1), 1);
                chk("stall_data1", int'(od1), int'(pd1));
            end
            chk("rdy_vs_occ8", int'(in_ready), int'(occupancy != 2'd2));
            chk("rdy_vs_occ1", int'(ir1), int'(occ1 != 2'd2));
            rst       = 1'b1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            rst1      = 1'b1;
            iv1       = 1'($urandom_range(0, 1));
            id1       = 1'($urandom_range(0, 1));
            or1       = 1'($urandom_range(0, 1));
            model8_update();
            model1_update();
            pv8 = out_valid; pd8 = out_data; pr8 = out_ready;
            pv1 = ov1;       pd1 = od1;      pr1 = or1;
            @(posedge clk);
            @(negedge clk);
            check8();
            check1();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
